// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 message schedule, streams Wt/Kt for rounds 0..63 from a 16-word window
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start_i, block_i   capture a padded 512-bit block (big-endian words) and begin; honoured in IDLE only
//   adv_i              consumer used the current Wt/Kt; step to the next round
//   ready_o, valid_o   IDLE / RUN indicators
//   wt_o, kt_o, round_o  current W[t], K[t] and t; zero outside RUN
//   done_o             one-cycle pulse after round 63 is consumed
module sha256_msg_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [511:0] block_i,
    input  logic         adv_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [31:0]  wt_o,
    output logic [31:0]  kt_o,
    output logic [5:0]   round_o,
    output logic         done_o
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t      state, state_nxt;
    logic [31:0] w [16];
    logic [5:0]  cnt;
    logic [31:0] w_new;
    logic        run, step, last;

    // w[0] is the current round word; w[15] receives W[t+16]
    assign w_new = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];
    assign run   = state == RUN;
    assign step  = run && adv_i;
    assign last  = step && cnt == 6'd63;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            done_o <= 1'b0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else begin
            state  <= state_nxt;
            done_o <= last;
            if (!run && start_i) begin
                for (int i = 0; i < 16; i++) w[i] <= block_i[511-32*i -: 32];
                cnt <= '0;
            end else if (step) begin
                for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                w[15] <= w_new;
                cnt   <= cnt + 6'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ready_o   = !run;
        valid_o   = run;
        wt_o      = run ? w[0] : 32'd0;
        kt_o      = run ? K_ROM[cnt] : 32'd0;
        round_o   = run ? cnt : 6'd0;
        if (!run && start_i) state_nxt = RUN;
        else if (last) state_nxt = IDLE;
    end
endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: directed checks of the SHA-256 message schedule against a full-expansion model
module tb_sha256_msg_sched;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic [511:0] block_i = '0;
    logic         adv_i = 1'b0;
    logic         ready_o, valid_o, done_o;
    logic [31:0]  wt_o, kt_o;
    logic [5:0]   round_o;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_w [64];

    localparam logic [31:0] K_REF [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_msg_sched dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .block_i(block_i), .adv_i(adv_i),
        .ready_o(ready_o), .valid_o(valid_o), .wt_o(wt_o), .kt_o(kt_o), .round_o(round_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // reference: plain 64-word expansion of the block
    task automatic model(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10)) + exp_w[t-7]
                     + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3)) + exp_w[t-16];
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom();
        return b;
    endfunction

    // leaves the bench at the negedge one cycle after the accepted start edge
    task automatic start_block(input logic [511:0] b);
        @(negedge clk);
        block_i = b;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || wt_o !== 32'd0 || kt_o !== 32'd0 || round_o !== 6'd0 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL reset: ready=%b valid=%b wt=%h kt=%h round=%0d done=%b, expected 1 0 0 0 0 0",
                     ready_o, valid_o, wt_o, kt_o, round_o, done_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        adv_i = 1'b1;
        @(negedge clk);
        total++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || round_o !== 6'd0) begin
            bad++;
            $display("FAIL idle_adv: ready=%b valid=%b round=%0d, expected 1 0 0", ready_o, valid_o, round_o);
        end
    endtask

    task automatic test_abc();
        logic [511:0] b;
        logic [31:0] sw [64];
        logic [31:0] sk [64];
        int nvalid, done_at, ndone, seq_err;
        b = '0;
        b[511:480] = 32'h61626380;
        b[31:0] = 32'h00000018;
        for (int i = 0; i < 64; i++) begin sw[i] = 32'hdeadbeef; sk[i] = 32'hdeadbeef; end
        nvalid = 0; done_at = 0; ndone = 0; seq_err = 0;
        adv_i = 1'b1;
        @(negedge clk);
        block_i = b;
        start_i = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (valid_o) begin
                if (round_o != nvalid[5:0]) seq_err++;
                sw[round_o] = wt_o;
                sk[round_o] = kt_o;
                nvalid++;
            end
            if (done_o) begin
                ndone++;
                if (done_at == 0) done_at = k;
            end
        end
        total++;
        if (sw[0] !== 32'h61626380) begin bad++; $display("FAIL abc_w0: got %h, expected 61626380", sw[0]); end
        for (int i = 1; i < 15; i++) begin
            total++;
            if (sw[i] !== 32'd0) begin bad++; $display("FAIL abc_w%0d: got %h, expected 00000000", i, sw[i]); end
        end
        total++;
        if (sw[15] !== 32'h00000018) begin bad++; $display("FAIL abc_w15: got %h, expected 00000018", sw[15]); end
        total++;
        if (sw[16] !== 32'h61626380) begin bad++; $display("FAIL abc_w16: got %h, expected 61626380", sw[16]); end
        total++;
        if (sw[17] !== 32'h000f0000) begin bad++; $display("FAIL abc_w17: got %h, expected 000f0000", sw[17]); end
        total++;
        if (sk[0] !== 32'h428a2f98) begin bad++; $display("FAIL abc_k0: got %h, expected 428a2f98", sk[0]); end
        total++;
        if (sk[63] !== 32'hc67178f2) begin bad++; $display("FAIL abc_k63: got %h, expected c67178f2", sk[63]); end
        total++;
        if (done_at != 65 || ndone != 1) begin
            bad++;
            $display("FAIL abc_done: at cycle %0d with %0d pulses, expected cycle 65 with 1 pulse", done_at, ndone);
        end
        total++;
        if (nvalid != 64 || seq_err != 0) begin
            bad++;
            $display("FAIL abc_rounds: %0d valid cycles, %0d out of order, expected 64 and 0", nvalid, seq_err);
        end
    endtask

    task automatic test_full();
        int idx;
        for (int r = 0; r < 3; r++) begin
            logic [511:0] b;
            b = rand_block();
            model(b);
            adv_i = 1'b1;
            start_block(b);
            idx = 0;
            for (int c = 0; c < 400 && idx < 64; c++) begin
                total++;
                if (valid_o !== 1'b1 || done_o !== 1'b0 || round_o != idx[5:0] || wt_o !== exp_w[idx] || kt_o !== K_REF[idx]) begin
                    bad++;
                    $display("FAIL full%0d: valid=%b round=%0d wt=%h kt=%h, expected valid=1 round=%0d wt=%h kt=%h",
                             r, valid_o, round_o, wt_o, kt_o, idx, exp_w[idx], K_REF[idx]);
                end
                adv_i = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (adv_i) idx++;
            end
            total++;
            if (idx != 64 || done_o !== 1'b1 || valid_o !== 1'b0) begin
                bad++;
                $display("FAIL full%0d_end: rounds=%0d done=%b valid=%b, expected 64 1 0", r, idx, done_o, valid_o);
            end
        end
    endtask

    task automatic test_stall();
        logic [511:0] b;
        int idx;
        b = rand_block();
        model(b);
        adv_i = 1'b1;
        start_block(b);
        idx = 0;
        for (int c = 0; c < 200 && idx < 64; c++) begin
            total++;
            if (valid_o !== 1'b1 || round_o != idx[5:0] || wt_o !== exp_w[idx] || kt_o !== K_REF[idx]) begin
                bad++;
                $display("FAIL stall_run: round=%0d wt=%h kt=%h, expected round=%0d wt=%h kt=%h",
                         round_o, wt_o, kt_o, idx, exp_w[idx], K_REF[idx]);
            end
            if (idx == 10 && c == 10) begin
                adv_i = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    total++;
                    if (valid_o !== 1'b1 || round_o !== 6'd10 || wt_o !== exp_w[10] || kt_o !== K_REF[10]) begin
                        bad++;
                        $display("FAIL stall_hold: round=%0d wt=%h kt=%h, expected round=10 wt=%h kt=%h",
                                 round_o, wt_o, kt_o, exp_w[10], K_REF[10]);
                    end
                end
                adv_i = 1'b1;
            end
            @(negedge clk);
            idx++;
        end
        total++;
        if (done_o !== 1'b1 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL stall_end: done=%b ready=%b, expected 1 1", done_o, ready_o);
        end
    endtask

    task automatic test_start_in_run();
        logic [511:0] a;
        int idx;
        a = rand_block();
        model(a);
        adv_i = 1'b1;
        start_block(a);
        idx = 0;
        for (int c = 0; c < 200 && idx < 64; c++) begin
            total++;
            if (valid_o !== 1'b1 || round_o != idx[5:0] || wt_o !== exp_w[idx] || kt_o !== K_REF[idx]) begin
                bad++;
                $display("FAIL start_in_run: round=%0d wt=%h kt=%h, expected round=%0d wt=%h kt=%h",
                         round_o, wt_o, kt_o, idx, exp_w[idx], K_REF[idx]);
            end
            if (idx == 30) begin
                block_i = ~a;
                start_i = 1'b1;
            end
            @(negedge clk);
            start_i = 1'b0;
            idx++;
        end
        total++;
        if (done_o !== 1'b1 || valid_o !== 1'b0) begin
            bad++;
            $display("FAIL start_in_run_end: done=%b valid=%b, expected 1 0", done_o, valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] a, b;
        int idx;
        a = rand_block();
        b = rand_block();
        model(a);
        adv_i = 1'b1;
        start_block(a);
        for (int blk = 0; blk < 2; blk++) begin
            idx = 0;
            for (int c = 0; c < 200 && idx < 64; c++) begin
                total++;
                if (valid_o !== 1'b1 || round_o != idx[5:0] || wt_o !== exp_w[idx] || kt_o !== K_REF[idx]) begin
                    bad++;
                    $display("FAIL b2b%0d: valid=%b round=%0d wt=%h kt=%h, expected valid=1 round=%0d wt=%h kt=%h",
                             blk, valid_o, round_o, wt_o, kt_o, idx, exp_w[idx], K_REF[idx]);
                end
                @(negedge clk);
                idx++;
            end
            total++;
            if (done_o !== 1'b1 || ready_o !== 1'b1) begin
                bad++;
                $display("FAIL b2b%0d_done: done=%b ready=%b, expected 1 1", blk, done_o, ready_o);
            end
            if (blk == 0) begin
                model(b);
                block_i = b;
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end
        end
        @(negedge clk);
        total++;
        if (done_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_pulse: done=%b ready=%b one cycle later, expected 0 1", done_o, ready_o);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [511:0] a, b;
        int ndone;
        a = rand_block();
        b = rand_block();
        model(a);
        adv_i = 1'b1;
        start_block(a);
        for (int i = 0; i < 20; i++) @(negedge clk);
        total++;
        if (round_o !== 6'd20 || wt_o !== exp_w[20]) begin
            bad++;
            $display("FAIL rst_pre: round=%0d wt=%h, expected 20 %h", round_o, wt_o, exp_w[20]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || wt_o !== 32'd0 || kt_o !== 32'd0 || round_o !== 6'd0) begin
            bad++;
            $display("FAIL rst_mid: valid=%b ready=%b wt=%h kt=%h round=%0d, expected 0 1 0 0 0",
                     valid_o, ready_o, wt_o, kt_o, round_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done_o !== 1'b0 || ready_o !== 1'b1) ndone++;
        end
        total++;
        if (ndone != 0) begin bad++; $display("FAIL rst_no_done: %0d cycles with done or not ready, expected 0", ndone); end
        model(b);
        start_block(b);
        total++;
        if (valid_o !== 1'b1 || round_o !== 6'd0 || wt_o !== exp_w[0] || kt_o !== K_REF[0]) begin
            bad++;
            $display("FAIL rst_restart: valid=%b round=%0d wt=%h kt=%h, expected 1 0 %h %h",
                     valid_o, round_o, wt_o, kt_o, exp_w[0], K_REF[0]);
        end
        @(negedge clk);
        total++;
        if (round_o !== 6'd1 || wt_o !== exp_w[1]) begin
            bad++;
            $display("FAIL rst_restart1: round=%0d wt=%h, expected 1 %h", round_o, wt_o, exp_w[1]);
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_full();
        test_stall();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- Message-schedule stage directly upstream of the SHA-256 round core.
- Accepts one padded 512-bit block and, for rounds t = 0..63, presents the round word Wt and the round constant Kt.
- Wt is computed on the fly from a 16-word sliding window, so no 64-word array is stored.
- Its outputs drive the round core's Wt_i/Kt_i inputs; the core's per-round enable drives adv_i.

Parameters:
- none (round count fixed at 64, word width fixed at 32 per FIPS 180-4)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  capture block_i and begin schedule; honoured only in IDLE
- block_i  in  512  padded message block, big-endian; word 0 = block_i[511:480], word 15 = block_i[31:0]
- adv_i  in  1  consumer has used the current Wt/Kt; step to next round
- ready_o  out  1  high in IDLE; block may be started
- valid_o  out  1  high in RUN; Wt_o/Kt_o/round_o are meaningful
- wt_o  out  32  current message-schedule word W[round]
- kt_o  out  32  current round constant K[round]
- round_o  out  6  current round index t
- done_o  out  1  one-cycle pulse after round 63 is consumed

Behaviour:
- Reset (async assert, any state):
  - state = IDLE; window w[0..15] = 0; cnt = 0; done_o = 0.
  - Outputs: ready_o = 1, valid_o = 0, wt_o = 0, kt_o = 0, round_o = 0.
- States: IDLE, RUN.
- IDLE:
  - start_i = 1 at a clk edge: w[i] <= block_i[511-32i -: 32], cnt <= 0, state <= RUN.
  - Latency: valid_o = 1 with W0 on the cycle after start_i.
- RUN outputs (combinational from registers):
  - wt_o = w[0]; kt_o = K[cnt] from an internal 64-entry constant ROM.
  - round_o = cnt; valid_o = 1; ready_o = 0.
- RUN with adv_i = 1 at an edge:
  - w[i] <= w[i+1] for i = 0..14.
  - w[15] <= σ1(w[14]) + w[9] + σ0(w[1]) + w[0], modulo 2^32, carries discarded.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3; σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - cnt <= cnt + 1.
- RUN with adv_i = 0: every register holds; outputs stable indefinitely (stall).
- Last round, cnt = 63 and adv_i = 1:
  - state <= IDLE, done_o <= 1 for exactly one cycle, cnt <= 0. No wrap back to round 0 in RUN.
- Outside RUN: wt_o and kt_o forced to 0; round_o = 0.
- start_i while in RUN: ignored; the current schedule is not disturbed.
- start_i in the same cycle done_o is high (state is IDLE): accepted, giving back-to-back blocks.
- Throughput: with adv_i held high, start to done_o takes 1 + 64 cycles.
- adv_i while in IDLE: ignored.
- Reset asserted mid-RUN: immediate return to IDLE; no done_o pulse; the partial block is discarded.
- block_i is sampled only on the accepted start_i edge; later changes have no effect.

Test Plan:
- Reset values: assert rst_n = 0 mid-RUN (round 20) -> same cycle valid_o = 0, ready_o = 1, wt_o = 0; after release no done_o; a fresh start_i begins at round_o = 0.
- "abc" block: block_i = 0x61626380, then fourteen zero words, then 0x00000018; start_i with adv_i = 1 continuously ->
  - W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018;
  - W16 = 0x61626380, W17 = 0x000F0000;
  - K0 = 0x428a2f98, K63 = 0xc67178f2;
  - done_o pulses exactly 65 cycles after start.
- Full-schedule check: random blocks vs a reference model -> all 64 (round_o, wt_o, kt_o) triples match, round_o strictly 0..63.
- Stall: drop adv_i for 5 cycles at round 10 -> wt_o/kt_o/round_o constant during the stall; sequence resumes at round 11 with correct W11.
- Start during RUN: pulse start_i with a different block at round 30 -> ignored; rounds 31..63 still follow the original block.
- Back-to-back: assert start_i in the done_o cycle -> the next block's W0 is valid on the following cycle with round_o = 0; no gap round and no stale data.
